// File: rtl/event_encoder_pkg.sv
// event_pkg: shared sizes, slot state encoding and one-hot helper for the event encoder
package event_pkg;
    localparam int N_SRC = 8;
    localparam int CODE_W = 3;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_t;
    function automatic logic [N_SRC-1:0] onehot(input logic [CODE_W-1:0] i);
        return N_SRC'(1) << i;
    endfunction
endpackage

// File: rtl/event_encoder_if.sv
// event_encoder_if: code output handshake between the encoder and its consumer
interface event_encoder_if;
    import event_pkg::*;
    logic [CODE_W-1:0] Dout;
    logic Dout_valid;
    logic Dout_ready;
    modport master(output Dout, output Dout_valid, input Dout_ready);
    modport slave(input Dout, input Dout_valid, output Dout_ready);
endinterface

// File: rtl/event_encoder_prio_sel.sv
// prio_sel: finds the first set request at or after start, wrapping from the top index to 0
module prio_sel
    import event_pkg::*;
(
    input  logic [N_SRC-1:0]  req,
    input  logic [CODE_W-1:0] start,
    output logic              found,
    output logic [CODE_W-1:0] idx
);
    // scan from the far end downward so the closest hit to start is written last
    always_comb begin
        found = 1'b0;
        idx = start;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (req[start + CODE_W'(k)]) begin
                found = 1'b1;
                idx = start + CODE_W'(k);
            end
        end
    end
endmodule

// File: rtl/event_encoder.sv
// event_encoder: collects sticky event requests and issues their source codes one per handshake
module event_encoder
    import event_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SRC-1:0]    Din,
    event_encoder_if.master     out,
    output logic [N_SRC-1:0]    pending,
    output logic                overflow,
    output logic                busy
);
    slot_t state, state_nxt;
    logic [CODE_W-1:0] ptr, start, sel, code;
    logic [N_SRC-1:0] clr;
    logic found, load;

    assign start = RR_EN ? ptr : '0;
    assign load = found && (state == EMPTY || out.Dout_ready);
    assign clr = load ? onehot(sel) : '0;

    prio_sel u_sel (
        .req  (pending),
        .start(start),
        .found(found),
        .idx  (sel)
    );

    // slot state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else state <= state_nxt;
    end

    // slot fills whenever it is free (empty or being accepted) and something is pending
    always_comb begin
        state_nxt = (state == EMPTY || out.Dout_ready) ? (found ? FULL : EMPTY) : FULL;
    end

    // outputs derived from registered state
    always_comb begin
        out.Dout_valid = (state == FULL);
        out.Dout = code;
        busy = (|pending) | (state == FULL);
    end

    // code, round-robin pointer, sticky pending and overflow; a re-request of the bit being loaded is a fresh event
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code <= '0;
            ptr <= '0;
            pending <= '0;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                code <= sel;
                ptr <= sel + CODE_W'(1);
            end
            pending <= (pending & ~clr) | Din;
            overflow <= overflow | (|(Din & pending & ~clr));
        end
    end
endmodule

// File: tb/tb_event_encoder.sv
// tb_event_encoder: randomized and directed scoreboard check of both priority modes
module tb_event_encoder;
    import event_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] din = '0;
    logic rdy = 1'b0;
    logic [7:0] pend0, pend1;
    logic ovf0, ovf1, busy0, busy1;

    always #5 clk = ~clk;

    event_encoder_if if0 ();
    event_encoder_if if1 ();
    assign if0.Dout_ready = rdy;
    assign if1.Dout_ready = rdy;

    event_encoder #(.RR_EN(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .Din(din), .out(if0),
        .pending(pend0), .overflow(ovf0), .busy(busy0)
    );
    event_encoder #(.RR_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .Din(din), .out(if1),
        .pending(pend1), .overflow(ovf1), .busy(busy1)
    );

    typedef struct {
        logic [7:0] pend;
        int held;
        int last;
        int code;
        bit ovf;
    } mdl_t;

    mdl_t m0, m1;
    int q0[$], q1[$];
    int checks = 0, errors = 0;
    bit armed = 0;

    function automatic int step(inout mdl_t s, input logic [7:0] d, input bit r, input bit rst, input bit rr);
        int pick = -1;
        if (rst) begin
            s.pend = '0; s.held = -1; s.last = 7; s.code = 0; s.ovf = 0;
            return -1;
        end
        if (s.held < 0 || r) begin
            s.held = -1;
            for (int k = 0; k < 8; k++) begin
                int i = rr ? (s.last + 1 + k) % 8 : k;
                if (pick < 0 && s.pend[i]) pick = i;
            end
        end
        for (int i = 0; i < 8; i++)
            if (d[i] && s.pend[i] && i != pick) s.ovf = 1;
        if (pick >= 0) begin
            s.pend[pick] = 1'b0;
            s.held = pick; s.code = pick; s.last = pick;
        end
        s.pend = s.pend | d;
        return pick;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [7:0] d, input bit r, input bit rn);
        int p;
        din = d; rdy = r; rst_n = rn;
        @(posedge clk);
        p = step(m0, d, r, !rn, 1'b0);
        if (!rn) q0.delete(); else if (p >= 0) q0.push_back(p);
        p = step(m1, d, r, !rn, 1'b1);
        if (!rn) q1.delete(); else if (p >= 0) q1.push_back(p);
        #1;
    endtask

    // monitor: register-level checks every cycle, code checks on each accepted handshake
    always @(negedge clk) begin
        if (armed) begin
            chk("pend0", int'(pend0), int'(m0.pend));
            chk("ovf0", int'(ovf0), int'(m0.ovf));
            chk("valid0", int'(if0.Dout_valid), int'(m0.held >= 0));
            chk("busy0", int'(busy0), int'(m0.pend != 0 || m0.held >= 0));
            chk("dout0", int'(if0.Dout), m0.code);
            chk("pend1", int'(pend1), int'(m1.pend));
            chk("ovf1", int'(ovf1), int'(m1.ovf));
            chk("valid1", int'(if1.Dout_valid), int'(m1.held >= 0));
            chk("busy1", int'(busy1), int'(m1.pend != 0 || m1.held >= 0));
            chk("dout1", int'(if1.Dout), m1.code);
            if (if0.Dout_valid && rdy) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb0: unexpected code %0d with empty scoreboard", if0.Dout);
                end else chk("sb0_code", int'(if0.Dout), q0.pop_front());
            end
            if (if1.Dout_valid && rdy) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb1: unexpected code %0d with empty scoreboard", if1.Dout);
                end else chk("sb1_code", int'(if1.Dout), q1.pop_front());
            end
        end
    end

    initial begin
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h00, 1'b0, 1'b0);
        armed = 1;
        tick(8'h04, 1'b1, 1'b1);
        repeat (3) tick(8'h00, 1'b1, 1'b1);
        tick(8'hA5, 1'b1, 1'b1);
        repeat (6) tick(8'h00, 1'b1, 1'b1);
        tick(8'h80, 1'b1, 1'b1);
        repeat (3) tick(8'h00, 1'b1, 1'b1);
        tick(8'h81, 1'b1, 1'b1);
        repeat (3) tick(8'h00, 1'b1, 1'b1);
        tick(8'hFF, 1'b1, 1'b1);
        repeat (10) tick(8'h00, 1'b1, 1'b1);
        tick(8'h03, 1'b0, 1'b1);
        repeat (5) tick(8'h00, 1'b0, 1'b1);
        chk("bp_pending", int'(pend0), 2);
        repeat (4) tick(8'h00, 1'b1, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b1);
        tick(8'h02, 1'b0, 1'b1);
        tick(8'h02, 1'b0, 1'b1);
        tick(8'h02, 1'b0, 1'b1);
        chk("ovf_set", int'(ovf0), 1);
        tick(8'h00, 1'b0, 1'b0);
        tick(8'h01, 1'b0, 1'b1);
        tick(8'h01, 1'b0, 1'b1);
        chk("collide_no_ovf", int'(ovf0), 0);
        repeat (4) tick(8'h00, 1'b1, 1'b1);
        tick(8'hF1, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b1);
        tick(8'h00, 1'b0, 1'b0);
        chk("rst_busy", int'(busy0), 0);
        repeat (400) tick(8'($urandom & $urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 60) != 0);
        repeat (12) tick(8'h00, 1'b1, 1'b1);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/event_encoder.md
EVENT_ENCODER -- requirements
Module: event_encoder

Interface
REQ-001 The block SHALL have parameter RR_EN, default 0, meaning 0 = fixed priority (lowest index first) and 1 = round-robin priority.
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-004 The block SHALL have port Din, input, 8, one event-request line per source; a bit high in a cycle is one event.
REQ-005 The block SHALL have port Dout, output, 3, binary code of the issued source index.
REQ-006 The block SHALL have port Dout_valid, output, 1, Dout holds an unaccepted code.
REQ-007 The block SHALL have port Dout_ready, input, 1, consumer accepts Dout when Dout_valid and Dout_ready are both high.
REQ-008 The block SHALL have port pending, output, 8, registered sticky not-yet-issued events.
REQ-009 The block SHALL have port overflow, output, 1, sticky flag for a lost event.
REQ-010 The block SHALL have port busy, output, 1, equal to (|pending) | Dout_valid.

Function
REQ-011 Any Din[i] high at an edge SHALL set pending[i] at that edge.
REQ-012 Output slot states SHALL be EMPTY (Dout_valid=0) and FULL (Dout_valid=1).
REQ-013 EMPTY->FULL SHALL occur at an edge where pending is nonzero, loading the selected index into Dout and clearing that pending bit.
REQ-014 FULL with accept and nonzero pending SHALL reload Dout with the next selection in the same edge and stay FULL (back-to-back, one code per cycle).
REQ-015 FULL with accept and zero pending SHALL go to EMPTY.
REQ-016 FULL without accept SHALL hold Dout and Dout_valid stable.
REQ-017 Selection SHALL use only the pending register, not same-cycle Din, giving minimum latency Din edge k -> Dout_valid at edge k+1.
REQ-018 With RR_EN=0, the lowest set pending index SHALL be selected.
REQ-019 With RR_EN=1, the search SHALL start at (last issued index + 1) mod 8 and wrap 7->0.
REQ-020 The round-robin pointer SHALL reset to 0, so the first search starts at index 0.
REQ-021 If Din[i] is high in the same cycle that pending[i] is loaded into Dout, pending[i] SHALL remain 1 as a new event, with no overflow.
REQ-022 If Din[i] is high while pending[i]=1 and pending[i] is not being loaded that cycle, overflow SHALL set.
REQ-023 Overflow SHALL stay set until reset.
REQ-024 While Dout_valid=0, Dout SHALL retain its last value.
REQ-025 Dout_ready while EMPTY SHALL have no effect.

Reset
REQ-026 At an edge with rst_n=0, Dout=0, Dout_valid=0, pending=0, overflow=0 and the round-robin pointer=0 SHALL be set; Din is ignored that cycle.
REQ-027 Reset asserted mid-transfer SHALL discard the held code and all pending events without an accept being required.
REQ-028 After reset deasserts, Din SHALL be sampled from the first edge with rst_n=1.

Structure
REQ-029 Shared package event_pkg SHALL hold N_SRC=8, CODE_W=3 and the slot state encoding (EMPTY, FULL).
REQ-030 One combinational sub-module prio_sel SHALL take pending plus a start index and return found plus the 3-bit index; it is used for both priority modes (start index fixed at 0 when RR_EN=0).
REQ-031 All outputs SHALL be registered except busy, which is derived from registers.

Verification
REQ-032 Single event: Din=8'b0000_0100 for one cycle, Dout_ready=1 -> next cycle Dout=3'd2 and Dout_valid=1 for exactly one cycle; pending=0 afterward.
REQ-033 Fixed priority burst (RR_EN=0): Din=8'hA5 for one cycle, Dout_ready=1 -> codes 0,2,5,7 on consecutive cycles, then EMPTY, busy=0.
REQ-034 Round-robin (RR_EN=1): pending=8'h81 after last issue=7 -> 0 issued before 7; Din=8'hFF with ready=1 -> codes 0..7 in order.
REQ-035 Backpressure: Din=8'h03, Dout_ready=0 for 5 cycles -> Dout=0 held valid and pending=8'h02; then ready=1 -> 0 accepted, then 1.
REQ-036 Overflow and collision: Din[1] high twice while pending[1]=1 and ready=0 -> overflow=1. Din[0] high in the cycle code 0 loads -> code 0 issued twice, overflow unchanged.
REQ-037 Mid-operation reset: rst_n=0 for one cycle while FULL with pending=8'hF0 -> next cycle all outputs 0 and busy=0.
